// File: rtl/dio_loader.sv
// Download-to-memory loader: buffers dio byte strobes in a small FIFO and
// replays them as single-outstanding memory write requests per image type.
module dio_loader #(
    parameter int             AW       = 21,
    parameter logic [AW-1:0]  ROM_BASE = 21'h000000,
    parameter logic [AW-1:0]  DCK_BASE = 21'h010000,
    parameter logic [AW-1:0]  TZX_BASE = 21'h100000,
    parameter int             DEPTH    = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          romE,
    input  logic          dckE,
    input  logic          tzxE,
    input  logic [26:0]   dioA,
    input  logic [7:0]    dioD,
    input  logic          dioW,
    output logic [AW-1:0] memA,
    output logic [7:0]    memD,
    output logic          memReq,
    input  logic          memAck,
    output logic          busy,
    output logic          ovf,
    output logic          romDone,
    output logic          dckDone,
    output logic          tzxDone,
    output logic [19:0]   tzxSize
);

    localparam int PW = $clog2(DEPTH);
    localparam int EW = AW + 8;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, FINISH} state_t;
    typedef enum logic [1:0] {T_ROM, T_DCK, T_TZX} img_t;

    state_t state_q, state_d;
    img_t   type_q, type_d;

    logic [EW-1:0] fifo_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [PW:0]   cnt_q;
    logic          memReq_q;
    logic [AW-1:0] memA_q;
    logic [7:0]    memD_q;
    logic          ovf_q;
    logic [19:0]   maxoff_q;
    logic [19:0]   tzxSize_q;

    logic          any_en, own_en, other_en, in_win, full;
    logic          push_try, push, drop, pop;
    logic [AW-1:0] base, push_addr;
    logic [19:0]   off_p1;

    always_comb begin
        any_en   = romE | dckE | tzxE;
        own_en   = 1'b0;
        other_en = 1'b0;
        in_win   = 1'b0;
        base     = ROM_BASE;
        case (type_q)
            T_ROM: begin
                own_en   = romE;
                other_en = dckE | tzxE;
                in_win   = dioA < 27'd24576;
                base     = ROM_BASE;
            end
            T_DCK: begin
                own_en   = dckE;
                other_en = romE | tzxE;
                in_win   = dioA < 27'h0040000;
                base     = DCK_BASE;
            end
            T_TZX: begin
                own_en   = tzxE;
                other_en = romE | dckE;
                in_win   = dioA < 27'h0080000;
                base     = TZX_BASE;
            end
            default: ;
        endcase
        push_addr = base + AW'(dioA);
        off_p1    = {1'b0, dioA[18:0]} + 20'd1;
        full      = cnt_q == (PW+1)'(DEPTH);
        // Only strobes under the latched enable in LOAD count; others vanish silently.
        push_try  = (state_q == LOAD) && dioW && own_en;
        push      = push_try && in_win && !full;
        drop      = push_try && !(in_win && !full);
        pop       = (cnt_q != '0) && !memReq_q;
    end

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        case (state_q)
            IDLE: if (any_en) begin
                state_d = LOAD;
                type_d  = romE ? T_ROM : (dckE ? T_DCK : T_TZX);
            end
            LOAD:   if (!own_en || other_en) state_d = DRAIN;
            DRAIN:  if ((cnt_q == '0) && !memReq_q) state_d = FINISH;
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            type_q    <= T_ROM;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            memReq_q  <= 1'b0;
            memA_q    <= '0;
            memD_q    <= '0;
            ovf_q     <= 1'b0;
            maxoff_q  <= '0;
            tzxSize_q <= '0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: ;
            endcase
            // Ack and pop are exclusive: a pop needs memReq low, an ack needs it high.
            if (memReq_q && memAck) begin
                memReq_q <= 1'b0;
            end else if (pop) begin
                memReq_q <= 1'b1;
                {memA_q, memD_q} <= fifo_q[rptr_q];
            end
            if ((state_q == IDLE) && any_en) begin
                ovf_q    <= 1'b0;
                maxoff_q <= '0;
            end else begin
                if (drop) ovf_q <= 1'b1;
                if (push && (off_p1 > maxoff_q)) maxoff_q <= off_p1;
            end
            if ((state_q == FINISH) && (type_q == T_TZX)) tzxSize_q <= maxoff_q;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clock) begin
        if (push) fifo_q[wptr_q] <= {push_addr, dioD};
    end

    assign memA    = memA_q;
    assign memD    = memD_q;
    assign memReq  = memReq_q;
    assign ovf     = ovf_q;
    assign busy    = state_q != IDLE;
    assign romDone = (state_q == FINISH) && (type_q == T_ROM);
    assign dckDone = (state_q == FINISH) && (type_q == T_DCK);
    assign tzxDone = (state_q == FINISH) && (type_q == T_TZX);
    assign tzxSize = tzxSize_q;

endmodule

// File: tb/tb_dio_loader.sv
// Bench for dio_loader: directed and random downloads checked each cycle
// against a queue-based reference of accepted bytes and issued writes.
module tb_dio_loader;

    localparam int DEPTH = 4;
    localparam logic [20:0] RB = 21'h000000;
    localparam logic [20:0] DB = 21'h010000;
    localparam logic [20:0] TB = 21'h100000;
    localparam int P_IDLE = 0, P_LOAD = 1, P_DRAIN = 2, P_FIN = 3;

    logic        clock, reset, romE, dckE, tzxE, dioW, memAck;
    logic [26:0] dioA;
    logic [7:0]  dioD;
    logic [20:0] memA;
    logic [7:0]  memD;
    logic        memReq, busy, ovf, romDone, dckDone, tzxDone;
    logic [19:0] tzxSize;

    dio_loader dut (
        .clock(clock), .reset(reset), .romE(romE), .dckE(dckE), .tzxE(tzxE),
        .dioA(dioA), .dioD(dioD), .dioW(dioW), .memA(memA), .memD(memD),
        .memReq(memReq), .memAck(memAck), .busy(busy), .ovf(ovf),
        .romDone(romDone), .dckDone(dckDone), .tzxDone(tzxDone), .tzxSize(tzxSize)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0, bad = 0;
    int dly = 2, hold = 0, n_rom = 0, n_dck = 0, n_tzx = 0, m_acc = 0;
    bit stray = 0;
    logic [28:0] wlog[$];

    // reference state
    int          m_ph, m_ty, m_max, m_tsz;
    logic        m_req, m_ovf;
    logic [20:0] m_a;
    logic [7:0]  m_d;
    logic [28:0] m_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit en_of(int t);
        return (t == 0) ? romE : ((t == 1) ? dckE : tzxE);
    endfunction

    task automatic model_reset();
        m_ph = P_IDLE; m_ty = 0; m_max = 0; m_tsz = 0;
        m_req = 0; m_ovf = 0; m_a = '0; m_d = '0;
        m_q.delete();
    endtask

    task automatic model_step();
        bit own, other, pre_req;
        int pre_sz, lim;
        logic [20:0] base;
        pre_req = m_req;
        pre_sz  = m_q.size();
        own     = en_of(m_ty);
        other   = 0;
        for (int t = 0; t < 3; t++) if (t != m_ty && en_of(t)) other = 1;
        if (pre_req && memAck) m_req = 0;
        else if (!pre_req && pre_sz != 0) begin
            {m_a, m_d} = m_q.pop_front();
            m_req = 1;
        end
        if (m_ph == P_LOAD && dioW && own) begin
            lim  = (m_ty == 0) ? 24576 : ((m_ty == 1) ? (1 << 18) : (1 << 19));
            base = (m_ty == 0) ? RB : ((m_ty == 1) ? DB : TB);
            if (int'(dioA) < lim && pre_sz < DEPTH) begin
                m_q.push_back({base + dioA[20:0], dioD});
                if (int'(dioA) + 1 > m_max) m_max = int'(dioA) + 1;
                m_acc++;
            end else m_ovf = 1;
        end
        case (m_ph)
            P_IDLE: if (romE || dckE || tzxE) begin
                m_ph = P_LOAD; m_ty = romE ? 0 : (dckE ? 1 : 2);
                m_ovf = 0; m_max = 0;
            end
            P_LOAD:  if (!own || other) m_ph = P_DRAIN;
            P_DRAIN: if (pre_sz == 0 && !pre_req) m_ph = P_FIN;
            default: begin
                if (m_ty == 2) m_tsz = m_max % (1 << 20);
                m_ph = P_IDLE;
            end
        endcase
    endtask

    task automatic check_all();
        chk("memReq", memReq, m_req);
        if (m_req) begin
            chk("memA", memA, m_a);
            chk("memD", memD, m_d);
        end
        chk("busy", busy, m_ph != P_IDLE);
        chk("ovf", ovf, m_ovf);
        chk("romDone", romDone, m_ph == P_FIN && m_ty == 0);
        chk("dckDone", dckDone, m_ph == P_FIN && m_ty == 1);
        chk("tzxDone", tzxDone, m_ph == P_FIN && m_ty == 2);
        chk("tzxSize", tzxSize, m_tsz);
    endtask

    task automatic tick();
        if (memReq && memAck) wlog.push_back({memA, memD});
        @(posedge clock);
        if (reset) model_step();
        #1;
        check_all();
        if (romDone) n_rom++;
        if (dckDone) n_dck++;
        if (tzxDone) n_tzx++;
        if (memReq) hold++; else hold = 0;
        memAck = stray || (memReq && hold >= dly);
        stray = 0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        for (int k = 0; k < limit; k++) begin
            tick();
            if (m_ph == P_IDLE) break;
        end
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic strobe(input int a, input logic [7:0] d);
        dioA = 27'(a); dioD = d; dioW = 1; tick(); dioW = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int nr;
        logic [7:0] last_d;
        reset = 0; romE = 0; dckE = 0; tzxE = 0; dioW = 0; dioA = '0; dioD = '0; memAck = 0;
        model_reset();
        #3;
        check_all();
        chk("rst_memA", memA, 0);
        chk("rst_memD", memD, 0);
        tick(); tick();
        reset = 1;
        tick();

        // ROM: four bytes, ack two cycles after each request
        dly = 2; wlog.delete(); n_rom = 0;
        romE = 1; tick();
        for (int i = 0; i < 4; i++) begin
            strobe(i, 8'(11 * (i + 1))); tick(); tick();
        end
        romE = 0;
        wait_idle("rom", 100);
        chk("rom_nwr", wlog.size(), 4);
        for (int i = 0; i < 4 && i < wlog.size(); i++)
            chk("rom_wr", wlog[i], {21'(i), 8'(11 * (i + 1))});
        chk("rom_done", n_rom, 1);

        // DCK: out-of-window byte, stray ack, then offset 5, then a burst
        dly = 1; wlog.delete(); n_dck = 0;
        dckE = 1; tick();
        strobe(1 << 18, 8'h5A);
        chk("dck_ovf", ovf, 1);
        stray = 1; tick(); tick(); tick();
        chk("dck_noreq", memReq, 0);
        strobe(5, 8'hC3); tick();
        chk("dck_req", memReq, 1);
        chk("dck_addr", memA, 21'h010005);
        chk("dck_data", memD, 8'hC3);
        dly = 3;
        for (int i = 6; i < 20; i++) strobe(i, 8'($urandom));
        dckE = 0;
        wait_idle("dck", 200);
        chk("dck_done", n_dck, 1);
        chk("dck_first", wlog.size() > 0 ? wlog[0] : '0, {21'h010005, 8'hC3});

        // TZX: 1000 bytes against a slow memory; last byte sent after drain
        dly = 10; wlog.delete(); n_tzx = 0; m_acc = 0;
        tzxE = 1; tick();
        for (int i = 0; i < 999; i++) strobe(i, 8'($urandom));
        for (int i = 0; i < 80; i++) tick();
        last_d = 8'($urandom);
        strobe(999, last_d);
        chk("tzx_ovf", ovf, 1);
        tzxE = 0;
        wait_idle("tzx", 200);
        chk("tzx_size", tzxSize, 20'd1000);
        chk("tzx_done", n_tzx, 1);
        chk("tzx_nwr", wlog.size(), m_acc);
        chk("tzx_last", wlog.size() > 0 ? wlog[wlog.size()-1] : '0, {TB + 21'd999, last_d});

        // Reset mid-operation with request outstanding and three queued
        dly = 20; n_rom = 0;
        romE = 1; tick();
        for (int i = 0; i < 4; i++) strobe(i, 8'(i + 1));
        #2 reset = 0;
        #1;
        chk("arst_req", memReq, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", romDone, 0);
        chk("arst_memA", memA, 0);
        model_reset();
        romE = 0;
        tick(); tick();
        reset = 1;
        dly = 1; wlog.delete();
        romE = 1; tick();
        strobe(7, 8'hA7); strobe(8, 8'hA8);
        romE = 0;
        wait_idle("rom2", 100);
        chk("rom2_nwr", wlog.size(), 2);
        chk("rom2_done", n_rom, 1);
        chk("rom2_ovf", ovf, 0);

        // tzxE falls, romE rises next cycle
        n_rom = 0; n_tzx = 0;
        tzxE = 1; tick();
        strobe(0, 8'h10); strobe(1, 8'h11);
        tzxE = 0; tick();
        romE = 1;
        for (int k = 0; k < 50 && n_tzx == 0; k++) tick();
        chk("swap_tzxdone", n_tzx, 1);
        tick(); tick();
        chk("swap_rombusy", busy, 1);
        strobe(3, 8'h33);
        romE = 0;
        wait_idle("swap", 100);
        chk("swap_romdone", n_rom, 1);
        chk("swap_tzxsize", tzxSize, 20'd2);

        // Random loads
        for (int l = 0; l < 4; l++) begin
            nr = $urandom_range(0, 2);
            dly = $urandom_range(1, 4);
            romE = (nr == 0); dckE = (nr == 1); tzxE = (nr == 2);
            tick();
            for (int c = 0; c < 40; c++) begin
                dioW = 1'($urandom_range(0, 1));
                dioA = ($urandom_range(0, 9) == 0) ? 27'($urandom_range(24576, 600000))
                                                   : 27'($urandom_range(0, 300));
                dioD = 8'($urandom);
                tick();
            end
            dioW = 0; romE = 0; dckE = 0; tzxE = 0;
            wait_idle("rand", 300);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
